// File: rtl/ysyx22041405_exu_md.sv
// ysyx22041405_exu_md: execute unit with ALU, branch resolution and an
// iterative multiply/divide engine.
//
// Ports
//   clk, rst            clock (rising edge) / asynchronous active-low reset
//   in_valid, in_ready  operation handshake (in_ready only in IDLE)
//   pc, imm, rs1, rs2   operands
//   op                  operation code (ALU 0-9, MUL* 16-19, DIV*/REM* 20-23)
//   s1_sel, s2_sel      select pc / imm as ALU sources
//   br_type, br_inv     branch/jump kind and compare inversion
//   flush               abort the current operation
//   out_valid, out_ready result handshake
//   result, next_pc, link  operation result, next pc, pc+4 for jumps
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// MUL   | shift-add multiply, one bit per cycle
// DIV   | restoring divide, one bit per cycle
// DONE  | result presented until out_ready
module ysyx22041405_exu_md #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [4:0]       op,
  input  logic             s1_sel,
  input  logic             s2_sel,
  input  logic [2:0]       br_type,
  input  logic             br_inv,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] link
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] C_FOUR     = WIDTH'(4);
  localparam logic [WIDTH-1:0] C_MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;      // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]   r_opa;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   r_result, r_next_pc, r_link;
  logic [1:0]         r_op_lo;
  logic               r_neg_q, r_neg_r;

  logic [WIDTH-1:0] w_src1, w_src2, w_alu, w_npc, w_pc4, w_pc_imm;
  logic [SH_W-1:0]  w_shamt;
  logic             w_slt, w_sltu, w_taken;
  logic             w_is_mul, w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic             w_div_zero, w_div_ovf;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_div_special;

  assign w_src1   = s1_sel ? pc : rs1;
  assign w_src2   = s2_sel ? imm : rs2;
  assign w_shamt  = w_src2[SH_W-1:0];
  assign w_slt    = $signed(w_src1) < $signed(w_src2);
  assign w_sltu   = w_src1 < w_src2;
  assign w_pc4    = pc + C_FOUR;
  assign w_pc_imm = pc + imm;

  always_comb begin
    w_alu = w_src1 + w_src2;
    case (op)
      5'd1:    w_alu = w_src1 - w_src2;
      5'd2:    w_alu = w_src1 << w_shamt;
      5'd3:    w_alu = {{(WIDTH-1){1'b0}}, w_slt};
      5'd4:    w_alu = {{(WIDTH-1){1'b0}}, w_sltu};
      5'd5:    w_alu = w_src1 ^ w_src2;
      5'd6:    w_alu = w_src1 >> w_shamt;
      5'd7:    w_alu = $signed(w_src1) >>> w_shamt;
      5'd8:    w_alu = w_src1 | w_src2;
      5'd9:    w_alu = w_src1 & w_src2;
      default: w_alu = w_src1 + w_src2;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    w_npc   = w_pc4;
    case (br_type)
      3'd1:    w_npc = w_pc_imm;
      3'd2:    w_npc = (rs1 + imm) & {{(WIDTH-1){1'b1}}, 1'b0};
      3'd4:    w_taken = (rs1 == rs2);
      3'd5:    w_taken = (rs1 != rs2);
      3'd6:    w_taken = w_slt ^ br_inv;
      3'd7:    w_taken = w_sltu ^ br_inv;
      default: w_taken = 1'b0;
    endcase
    if (w_taken) w_npc = w_pc_imm;
  end

  // Operand signedness: MULHSU treats only src1 as signed, *U variants neither.
  assign w_is_mul   = (op[4:2] == 3'b100);
  assign w_is_div   = (op[4:2] == 3'b101);
  assign w_a_signed = (w_is_mul && (op[1:0] != 2'b11)) || (w_is_div && !op[0]);
  assign w_b_signed = (w_is_mul && !op[1]) || (w_is_div && !op[0]);
  assign w_a_neg    = w_a_signed && w_src1[WIDTH-1];
  assign w_b_neg    = w_b_signed && w_src2[WIDTH-1];
  assign w_mag_a    = w_a_neg ? -w_src1 : w_src1;
  assign w_mag_b    = w_b_neg ? -w_src2 : w_src2;
  assign w_div_zero = (w_src2 == '0);
  assign w_div_ovf  = !op[0] && (w_src1 == C_MIN_NEG) && (&w_src2);
  assign w_div_special = w_div_zero ? (op[1] ? w_src1 : '1) : (op[1] ? '0 : w_src1);

  // Multiply step: add multiplicand to the high half when the multiplier LSB is set, shift right.
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mstep, w_mfix;
  logic [WIDTH-1:0]   w_mul_res;
  assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opa} : '0);
  assign w_mstep   = {w_madd, r_acc[WIDTH-1:1]};
  assign w_mfix    = r_neg_q ? -w_mstep : w_mstep;
  assign w_mul_res = (r_op_lo == 2'b00) ? w_mfix[WIDTH-1:0] : w_mfix[2*WIDTH-1:WIDTH];

  // Divide step: shift the next dividend bit into the remainder and subtract when it fits.
  logic [WIDTH:0]     w_dsh;
  logic [WIDTH-1:0]   w_ddif, w_quo, w_rem, w_div_res;
  logic               w_dge;
  logic [2*WIDTH-1:0] w_dstep;
  assign w_dsh     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_dge     = w_dsh >= {1'b0, r_opa};
  assign w_ddif    = w_dsh[WIDTH-1:0] - r_opa;
  assign w_dstep   = {(w_dge ? w_ddif : w_dsh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_dge};
  assign w_quo     = w_dstep[WIDTH-1:0];
  assign w_rem     = w_dstep[2*WIDTH-1:WIDTH];
  assign w_div_res = r_op_lo[1] ? (r_neg_r ? -w_rem : w_rem) : (r_neg_q ? -w_quo : w_quo);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opa     <= '0;
      r_result  <= '0;
      r_next_pc <= '0;
      r_link    <= '0;
      r_op_lo   <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_next_pc <= w_npc;
          r_link    <= w_pc4;
          r_op_lo   <= op[1:0];
          r_neg_q   <= w_a_neg ^ w_b_neg;
          r_neg_r   <= w_a_neg;
          r_cnt     <= C_CNT_INIT;
          if (w_is_mul) begin
            r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
            r_opa   <= w_mag_a;
            r_state <= S_MUL;
          end else if (w_is_div && (w_div_zero || w_div_ovf)) begin
            r_result <= w_div_special;
            r_state  <= S_DONE;
          end else if (w_is_div) begin
            r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
            r_opa   <= w_mag_b;
            r_state <= S_DIV;
          end else begin
            r_result <= w_alu;
            r_state  <= S_DONE;
          end
        end
        S_MUL: begin
          r_acc <= w_mstep;
          if (r_cnt == '0) begin
            r_result <= w_mul_res;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DIV: begin
          r_acc <= w_dstep;
          if (r_cnt == '0) begin
            r_result <= w_div_res;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: if (out_ready) r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign next_pc   = r_next_pc;
  assign link      = r_link;

endmodule

// File: tb/tb_ysyx22041405_exu_md.sv
// Scoreboard bench for ysyx22041405_exu_md (WIDTH=32): the stimulus process
// pushes reference-model expectations, the monitor pops on each new result.
module tb_ysyx22041405_exu_md;

  logic        clk, rst, in_valid, in_ready, s1_sel, s2_sel, br_inv, flush;
  logic        out_valid, out_ready;
  logic [31:0] pc, imm, rs1, rs2, result, next_pc, link;
  logic [4:0]  op;
  logic [2:0]  br_type;

  ysyx22041405_exu_md #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .imm(imm), .rs1(rs1), .rs2(rs2), .op(op),
    .s1_sel(s1_sel), .s2_sel(s2_sel), .br_type(br_type), .br_inv(br_inv),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .next_pc(next_pc), .link(link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] npc;
    logic [31:0] lnk;
    int          lat;
    time         acc;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   stall   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: plain integer arithmetic on 32/64-bit values.
  function automatic exp_t model(input logic [4:0] o, input logic [31:0] p, im, r1, r2,
                                 input logic s1, s2, input logic [2:0] bt, input logic inv);
    exp_t e;
    logic [31:0] a, b;
    logic [63:0] prod;
    int sa, sbv;
    logic taken;
    a = s1 ? p : r1;
    b = s2 ? im : r2;
    sa = a;
    sbv = b;
    e.lat = 1;
    e.acc = 0;
    prod = '0;
    case (o)
      5'd1:  e.res = a - b;
      5'd2:  e.res = a << b[4:0];
      5'd3:  e.res = (sa < sbv) ? 32'd1 : 32'd0;
      5'd4:  e.res = (a < b) ? 32'd1 : 32'd0;
      5'd5:  e.res = a ^ b;
      5'd6:  e.res = a >> b[4:0];
      5'd7:  e.res = sa >>> b[4:0];
      5'd8:  e.res = a | b;
      5'd9:  e.res = a & b;
      5'd16: begin prod = longint'(sa) * longint'(sbv); e.res = prod[31:0]; e.lat = 33; end
      5'd17: begin prod = longint'(sa) * longint'(sbv); e.res = prod[63:32]; e.lat = 33; end
      5'd18: begin prod = longint'(sa) * longint'({32'h0, b}); e.res = prod[63:32]; e.lat = 33; end
      5'd19: begin prod = {32'h0, a} * {32'h0, b}; e.res = prod[63:32]; e.lat = 33; end
      5'd20: if (b == 0) e.res = 32'hffff_ffff;
             else if (a == 32'h8000_0000 && b == 32'hffff_ffff) e.res = a;
             else begin e.res = sa / sbv; e.lat = 33; end
      5'd21: if (b == 0) e.res = 32'hffff_ffff; else begin e.res = a / b; e.lat = 33; end
      5'd22: if (b == 0) e.res = a;
             else if (a == 32'h8000_0000 && b == 32'hffff_ffff) e.res = 0;
             else begin e.res = sa % sbv; e.lat = 33; end
      5'd23: if (b == 0) e.res = a; else begin e.res = a % b; e.lat = 33; end
      default: e.res = a + b;
    endcase
    taken = 1'b0;
    case (bt)
      3'd4: taken = (r1 == r2);
      3'd5: taken = (r1 != r2);
      3'd6: taken = (sa < sbv) ^ inv;
      3'd7: taken = (a < b) ^ inv;
      default: taken = 1'b0;
    endcase
    if (bt == 3'd1) e.npc = p + im;
    else if (bt == 3'd2) e.npc = (r1 + im) & 32'hffff_fffe;
    else e.npc = taken ? p + im : p + 32'd4;
    e.lnk = p + 32'd4;
    return e;
  endfunction

  task automatic issue(input logic [4:0] o, input logic [31:0] p, im, r1, r2,
                       input logic s1, s2, input logic [2:0] bt, input logic inv, input bit push);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    if (!in_ready) begin
      n_total++;
      $display("FAIL issue_timeout: in_ready stuck at 0 at %0t", $time);
      return;
    end
    op = o; pc = p; imm = im; rs1 = r1; rs2 = r2;
    s1_sel = s1; s2_sel = s2; br_type = bt; br_inv = inv;
    in_valid = 1'b1;
    @(posedge clk);
    if (push) begin
      e = model(o, p, im, r1, r2, s1, s2, bt, inv);
      e.acc = $time;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 1000) begin @(negedge clk); n++; end
    if (sb.size() != 0 || out_valid) begin
      n_total++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
    end
  endtask

  // Monitor: samples on the falling edge and chooses out_ready for the next rising edge.
  bit          seen = 0;
  logic [31:0] h_res, h_npc, h_lnk;
  always @(negedge clk) begin
    if (!rst) begin
      seen = 0;
      out_ready = 1'b0;
    end else if (out_valid) begin
      chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
      if (!seen) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: result %h with no pending op at %0t", result, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", {32'd0, result}, {32'd0, e.res});
          chk("next_pc", {32'd0, next_pc}, {32'd0, e.npc});
          chk("link", {32'd0, link}, {32'd0, e.lnk});
          chk("latency", 64'(($time - e.acc + 5) / 10), 64'(e.lat));
        end
        seen = 1;
        h_res = result; h_npc = next_pc; h_lnk = link;
      end else begin
        chk("hold_result", {32'd0, result}, {32'd0, h_res});
        chk("hold_next_pc", {32'd0, next_pc}, {32'd0, h_npc});
        chk("hold_link", {32'd0, link}, {32'd0, h_lnk});
      end
      if (stall > 0) begin out_ready = 1'b0; stall--; end
      else out_ready = ($urandom_range(0, 3) != 0);
      if (out_ready) seen = 0;
    end else begin
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hffff_ffff;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      4: return -32'($urandom_range(1, 40));
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] ops [20] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                           5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd12, 5'd31};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    pc = '0; imm = '0; rs1 = '0; rs2 = '0; op = '0;
    s1_sel = 1'b0; s2_sel = 1'b0; br_type = '0; br_inv = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_rst_next_pc", {32'd0, next_pc}, 64'd0);
    chk("post_rst_link", {32'd0, link}, 64'd0);

    issue(5'd0, 32'h1000, 32'h0, 32'd5, 32'hffff_fffd, 0, 0, 3'd0, 0, 1);
    issue(5'd19, 32'h0, 32'h0, 32'hffff_ffff, 32'hffff_ffff, 0, 0, 3'd0, 0, 1);
    issue(5'd16, 32'h0, 32'h0, 32'hffff_ffff, 32'hffff_ffff, 0, 0, 3'd0, 0, 1);
    issue(5'd20, 32'h0, 32'h0, 32'h8000_0000, 32'hffff_ffff, 0, 0, 3'd0, 0, 1);
    issue(5'd22, 32'h0, 32'h0, 32'h8000_0000, 32'hffff_ffff, 0, 0, 3'd0, 0, 1);
    issue(5'd21, 32'h0, 32'h0, 32'd7, 32'd0, 0, 0, 3'd0, 0, 1);
    issue(5'd23, 32'h0, 32'h0, 32'd7, 32'd0, 0, 0, 3'd0, 0, 1);
    issue(5'd3, 32'h100, 32'h20, 32'hffff_ffff, 32'd1, 0, 0, 3'd6, 0, 1);
    issue(5'd3, 32'h100, 32'h20, 32'hffff_ffff, 32'd1, 0, 0, 3'd6, 1, 1);
    issue(5'd0, 32'h400, 32'h0, 32'h203, 32'h0, 0, 1, 3'd2, 0, 1);

    // Consumer back-pressure for 5 cycles.
    drain();
    stall = 5;
    issue(5'd1, 32'h200, 32'h0, 32'd100, 32'd58, 0, 0, 3'd0, 0, 1);
    drain();

    // Flush in the middle of a divide: no result may ever appear.
    issue(5'd20, 32'h0, 32'h0, 32'd1000, 32'd7, 0, 0, 3'd0, 0, 0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (40) @(negedge clk);

    // Reset in the middle of a multiply.
    issue(5'd17, 32'h0, 32'h0, 32'h1234_5678, 32'h9abc_def0, 0, 0, 3'd0, 0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midmul_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midmul_rst_result", {32'd0, result}, 64'd0);
    chk("midmul_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    issue(5'd0, 32'h3000, 32'h0, 32'd11, 32'd22, 0, 0, 3'd0, 0, 1);
    drain();

    for (int i = 0; i < 80; i++) begin
      issue(ops[$urandom_range(0, 19)], $urandom & 32'hffff_fffc, rnd_operand(),
            rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
